sr_xfer_ctrl: RTL and testbench

//  Sequencer for the N-stage serial shift register (sr_in/sr_out/control/clk/reset).

---
 rtl/sr_pkg.sv | 21 ++
 rtl/sr_xfer_cnt.sv | 50 +++++
 rtl/sr_xfer_ctrl.sv | 177 +++++++++++++++++
 tb/tb_sr_xfer_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the serial shift-register transfer sequencer.
//   N_DEF / W_DEF : default stage count and word width
//   state_e       : sequencer state encoding
//   cnt_width()   : transfer counter width for a given N, W
package sr_pkg;

  localparam int unsigned N_DEF = 8;
  localparam int unsigned W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Counter must hold 0..N+W-1
  function automatic int unsigned cnt_width(input int unsigned n, input int unsigned w);
    return $clog2(n + w + 1);
  endfunction

endpackage

// File: rtl/sr_xfer_cnt.sv
// Loadable transfer-cycle up-counter with terminal and capture-window flags.
//   clk, rst     : clock, async active-high reset
//   i_load       : clear count to 0 (priority over i_en)
//   i_en         : increment count
//   o_cnt_nxt_c  : count value after the coming edge (combinational)
//   o_term_c     : count == N+W-1 (combinational)
//   o_win_c      : count >= N, capture window (combinational)
module sr_xfer_cnt
  import sr_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF,
  localparam int unsigned CW = cnt_width(N, W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt_nxt_c,
  output logic          o_term_c,
  output logic          o_win_c
);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  // Next count
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_load) begin
      w_cnt_nxt = '0;
    end else if (i_en) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_cnt_nxt_c = w_cnt_nxt;
  assign o_term_c    = (r_cnt == CW'(N + W - 1));
  assign o_win_c     = (r_cnt >= CW'(N));

endmodule

// File: rtl/sr_xfer_ctrl.sv
// Sequencer for an N-stage serial shift register: accepts a W-bit word on a
// start/ready handshake, shifts it out on sr_in, captures the word returning
// on sr_out N cycles later and presents it on data_out with a done pulse.
//   clk, reset : clock, async active-high reset
//   start      : transfer request, taken when ready
//   dir        : bit order sampled with start (0 LSB first, 1 MSB first)
//   abort      : cancels a running transfer
//   data_in    : word to send, sampled with start
//   sr_out     : serial data from the shift register
//   sr_in      : serial data to the shift register
//   control    : shift-register mode (latched dir while busy)
//   ready      : idle, can accept start
//   busy       : transfer in progress
//   done       : one-cycle completion pulse
//   data_out   : last completed received word
module sr_xfer_ctrl
  import sr_pkg::*;
#(
  parameter int unsigned N = N_DEF,
  parameter int unsigned W = W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         dir,
  input  logic         abort,
  input  logic [W-1:0] data_in,
  input  logic         sr_out,
  output logic         sr_in,
  output logic         control,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] data_out
);

  localparam int unsigned CW = cnt_width(N, W);
  localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

  state_e        r_state;
  state_e        w_state_nxt;
  logic [W-1:0]  r_tx;
  logic [W-1:0]  w_tx_nxt;
  logic          r_mode;
  logic          w_mode_nxt;
  logic [W-1:0]  r_rx;
  logic [W-1:0]  w_rx_nxt;
  logic [W-1:0]  r_data_out;
  logic          r_sr_in;
  logic          r_control;
  logic          r_ready;
  logic          r_busy;
  logic          r_done;

  logic          w_load;
  logic          w_en;
  logic          w_accept;
  logic          w_capture;
  logic          w_finish;
  logic          w_sr_in_nxt;
  logic [IW-1:0] w_idx;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_term;
  logic          w_win;

  sr_xfer_cnt #(
    .N (N),
    .W (W)
  ) u_cnt (
    .clk         (clk),
    .rst         (reset),
    .i_load      (w_load),
    .i_en        (w_en),
    .o_cnt_nxt_c (w_cnt_nxt),
    .o_term_c    (w_term),
    .o_win_c     (w_win)
  );

  // Next-state and counter control; abort wins over completion
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_en        = 1'b0;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_capture = w_win;
          if (w_term) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_en = 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Transmit latch and receive shifter
  always_comb begin
    w_tx_nxt   = w_accept ? data_in : r_tx;
    w_mode_nxt = w_accept ? dir : r_mode;
    w_rx_nxt   = r_rx;
    if (w_capture) begin
      if (r_mode) begin
        w_rx_nxt = (r_rx << 1) | W'(sr_out);
      end else begin
        w_rx_nxt = (r_rx >> 1) | (W'(sr_out) << (W - 1));
      end
    end
  end

  // Serial bit for the next cycle; zero padding once the word is sent
  always_comb begin
    w_sr_in_nxt = 1'b0;
    w_idx       = '0;
    if ((w_state_nxt == ST_SHIFT) && (w_cnt_nxt < CW'(W))) begin
      w_idx       = w_mode_nxt ? (IW'(W - 1) - IW'(w_cnt_nxt)) : IW'(w_cnt_nxt);
      w_sr_in_nxt = w_tx_nxt[w_idx];
    end
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_tx       <= '0;
      r_mode     <= 1'b0;
      r_rx       <= '0;
      r_data_out <= '0;
      r_sr_in    <= 1'b0;
      r_control  <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_mode    <= w_mode_nxt;
      r_rx      <= w_rx_nxt;
      if (w_finish) begin
        r_data_out <= w_rx_nxt;
      end
      r_sr_in   <= w_sr_in_nxt;
      r_control <= (w_state_nxt == ST_SHIFT) ? w_mode_nxt : 1'b0;
      r_ready   <= (w_state_nxt == ST_IDLE);
      r_busy    <= (w_state_nxt == ST_SHIFT);
      r_done    <= (w_state_nxt == ST_DONE);
    end
  end

  assign sr_in    = r_sr_in;
  assign control  = r_control;
  assign ready    = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data_out;

endmodule

// File: tb/tb_sr_xfer_ctrl.sv
// Directed bench for sr_xfer_ctrl driving an ideal 8-stage shift register.
module tb_sr_xfer_ctrl;

  localparam int unsigned N = 8;
  localparam int unsigned W = 8;

  logic         clk;
  logic         reset;
  logic         start;
  logic         dir;
  logic         abort;
  logic [W-1:0] data_in;
  logic         sr_out;
  logic         sr_in;
  logic         control;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;

  int n_checks;
  int n_fail;

  sr_xfer_ctrl #(
    .N (N),
    .W (W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dir      (dir),
    .abort    (abort),
    .data_in  (data_in),
    .sr_out   (sr_out),
    .sr_in    (sr_in),
    .control  (control),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .data_out (data_out)
  );

  // Ideal N-stage shift register in the loop
  logic [N-1:0] sr_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sr_q <= '0;
    else       sr_q <= {sr_q[N-2:0], sr_in};
  end
  assign sr_out = sr_q[N-1];

  initial clk = 1'b0;
  always #20 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    #500;
    n_checks++;
    if ({ready, busy, done, sr_in, control} !== 5'b10000) begin
      n_fail++;
      $display("FAIL reset_flags: got rdy/bsy/dn/sri/ctl=%b expected 10000",
               {ready, busy, done, sr_in, control});
    end
    n_checks++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_data: got %h expected 00", data_out);
    end
    #500;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #5 reset = 1'b1;
    #2;
    n_checks++;
    if ({ready, busy, done, sr_in, control, data_out} !== {5'b10000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_pulse: got flags=%b data=%h expected 10000/00",
               {ready, busy, done, sr_in, control}, data_out);
    end
    #3 reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got ready=%b busy=%b expected 1/0", ready, busy);
    end
  endtask

  task automatic test_loopback(input logic [7:0] v, input logic d);
    logic exp_bit;
    @(negedge clk);
    start = 1'b1; data_in = v; dir = d;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start = 1'b0;
      exp_bit = (i < 8) ? (d ? v[7-i] : v[i]) : 1'b0;
      n_checks++;
      if (sr_in !== exp_bit) begin
        n_fail++;
        $display("FAIL loop_sr_in[%0d] v=%h dir=%b: got %b expected %b", i, v, d, sr_in, exp_bit);
      end
      n_checks++;
      if ({busy, control, done, ready} !== {1'b1, d, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL loop_flags[%0d]: got bsy/ctl/dn/rdy=%b expected %b",
                 i, {busy, control, done, ready}, {1'b1, d, 2'b00});
      end
    end
    @(negedge clk);
    n_checks++;
    if ({done, busy, ready, control} !== 4'b1000) begin
      n_fail++;
      $display("FAIL loop_done: got dn/bsy/rdy/ctl=%b expected 1000", {done, busy, ready, control});
    end
    n_checks++;
    if (data_out !== v) begin
      n_fail++;
      $display("FAIL loop_data dir=%b: got %h expected %h", d, data_out, v);
    end
    @(negedge clk);
    n_checks++;
    if ({done, ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL loop_idle: got dn/rdy=%b expected 01", {done, ready});
    end
  endtask

  task automatic test_abort();
    logic saw_done;
    @(negedge clk);
    start = 1'b1; data_in = 8'h0F; dir = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if ({ready, busy, control, done} !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_flags: got rdy/bsy/ctl/dn=%b expected 1000", {ready, busy, control, done});
    end
    n_checks++;
    if (data_out !== 8'hA5) begin
      n_fail++;
      $display("FAIL abort_data: got %h expected a5", data_out);
    end
    saw_done = 1'b0;
    abort = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || ready !== 1'b1) saw_done = 1'b1;
    end
    abort = 1'b0;
    n_checks++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_quiet: got done/not-ready seen=%b expected 0", saw_done);
    end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int idx[2];
    logic [7:0] dat[2];
    bit got_ready;
    n_done = 0;
    idx[0] = 0; idx[1] = 0;
    dat[0] = '0; dat[1] = '0;
    @(negedge clk);
    start = 1'b1; data_in = 8'h3C; dir = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) data_in = 8'h5A;
      if (done === 1'b1) begin
        if (n_done < 2) begin
          idx[n_done] = k;
          dat[n_done] = data_out;
        end
        n_done++;
      end
    end
    start = 1'b0;
    n_checks++;
    if (n_done != 2) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d done pulses expected 2", n_done);
    end
    n_checks++;
    if (idx[0] != 17 || idx[1] != 35) begin
      n_fail++;
      $display("FAIL b2b_timing: got done at %0d,%0d expected 17,35", idx[0], idx[1]);
    end
    n_checks++;
    if (dat[0] !== 8'h3C || dat[1] !== 8'h5A) begin
      n_fail++;
      $display("FAIL b2b_data: got %h,%h expected 3c,5a", dat[0], dat[1]);
    end
    got_ready = 1'b0;
    for (int k = 0; k < 40 && !got_ready; k++) begin
      @(negedge clk);
      if (ready === 1'b1) got_ready = 1'b1;
    end
    n_checks++;
    if (!got_ready) begin
      n_fail++;
      $display("FAIL b2b_drain: got ready=%b expected 1 within 40 cycles", ready);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    @(negedge clk);
    start = 1'b1; data_in = 8'h96; dir = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #4;
    n_checks++;
    if ({busy, control, ready} !== 3'b110) begin
      n_fail++;
      $display("FAIL rstmid_pre: got bsy/ctl/rdy=%b expected 110", {busy, control, ready});
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({ready, busy, done, sr_in, control} !== 5'b10000) begin
      n_fail++;
      $display("FAIL rstmid_flags: got rdy/bsy/dn/sri/ctl=%b expected 10000",
               {ready, busy, done, sr_in, control});
    end
    n_checks++;
    if (data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_data: got %h expected 00", data_out);
    end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_checks++;
    if (saw_done !== 1'b0 || data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_after: got activity=%b data=%h expected 0/00", saw_done, data_out);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dir      = 1'b0;
    abort    = 1'b0;
    data_in  = '0;
    test_reset();
    test_loopback(8'hA5, 1'b0);
    test_abort();
    test_loopback(8'hC3, 1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
